// File: rtl/laser_search_ctrl.sv
// laser_search_ctrl: alternating two-centre coverage search over a 16x16 grid.
module laser_search_ctrl #(
    parameter int NPT       = 40,
    parameter int RADIUS_SQ = 16,
    parameter int MAX_PASS  = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic [5:0] RD_ADDR,
    input  logic [3:0] RD_X,
    input  logic [3:0] RD_Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic [5:0] COVER,
    output logic       BUSY,
    output logic       DONE
);
    typedef enum logic [2:0] {IDLE, SCAN1, SCAN2, CHECK, FIN} state_t;

    state_t     state, state_nx;
    logic [5:0] idx, acc, best, prev_cover, best_nx;
    logic [7:0] cand, pass;
    logic [3:0] best_x, best_y, best_x_nx, best_y_nx, fix_x, fix_y;
    logic       c2v, scan, accum, last, fix_v, hit, upd, fin_ok;

    function automatic logic covered(input logic [3:0] ax, ay, bx, by);
        logic [7:0] dx, dy;
        dx = {4'd0, (ax >= bx) ? ax - bx : bx - ax};
        dy = {4'd0, (ay >= by) ? ay - by : by - ay};
        return ({1'b0, dx * dx} + {1'b0, dy * dy}) <= 9'(RADIUS_SQ);
    endfunction

    assign scan      = state == SCAN1 || state == SCAN2;
    assign accum     = scan && idx < 6'(NPT);
    assign last      = scan && !accum && cand == 8'hFF;
    assign RD_ADDR   = accum ? idx : 6'd0;
    // SCAN1 holds C2 fixed (only once it exists); SCAN2 always holds C1 fixed
    assign fix_x     = state == SCAN1 ? C2X : C1X;
    assign fix_y     = state == SCAN1 ? C2Y : C1Y;
    assign fix_v     = state == SCAN2 || c2v;
    assign hit       = covered(RD_X, RD_Y, cand[3:0], cand[7:4]) ||
                       (fix_v && covered(RD_X, RD_Y, fix_x, fix_y));
    assign upd       = acc > best;
    assign best_nx   = upd ? acc : best;
    assign best_x_nx = upd ? cand[3:0] : best_x;
    assign best_y_nx = upd ? cand[7:4] : best_y;
    assign fin_ok    = COVER == prev_cover || pass == 8'(MAX_PASS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = START ? SCAN1 : IDLE;
            SCAN1:   state_nx = last ? SCAN2 : SCAN1;
            SCAN2:   state_nx = last ? CHECK : SCAN2;
            CHECK:   state_nx = fin_ok ? FIN : SCAN1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx <= '0; acc <= '0; best <= '0; prev_cover <= '0;
            cand <= '0; pass <= '0; best_x <= '0; best_y <= '0; c2v <= 1'b0;
            C1X <= '0; C1Y <= '0; C2X <= '0; C2Y <= '0; COVER <= '0;
            BUSY <= 1'b0; DONE <= 1'b0;
        end else begin
            DONE <= state == FIN;
            if (state == IDLE && START) begin
                BUSY <= 1'b1; pass <= 8'd1; c2v <= 1'b0; prev_cover <= '0;
                idx <= '0; cand <= '0; acc <= '0; best <= '0;
            end
            if (accum) begin
                acc <= acc + 6'(hit);
                idx <= idx + 6'd1;
            end else if (scan) begin
                acc    <= '0;
                idx    <= '0;
                cand   <= cand + 8'd1;
                best   <= last ? 6'd0 : best_nx;
                best_x <= best_x_nx;
                best_y <= best_y_nx;
                if (last && state == SCAN1) begin
                    C1X <= best_x_nx; C1Y <= best_y_nx; c2v <= 1'b1;
                end
                if (last && state == SCAN2) begin
                    C2X <= best_x_nx; C2Y <= best_y_nx; COVER <= best_nx;
                end
            end
            if (state == CHECK && !fin_ok) begin
                prev_cover <= COVER;
                pass       <= pass + 8'd1;
            end
            if (state == FIN) BUSY <= 1'b0;
        end
    end
endmodule

// File: tb/tb_laser_search_ctrl.sv
// tb_laser_search_ctrl: directed checks of search results, latency, reset and RD_ADDR sequencing.
module tb_laser_search_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] px [64], py [64];
    logic [5:0] rd_addr_a, rd_addr_b, cover_a, cover_b;
    logic [3:0] c1x_a, c1y_a, c2x_a, c2y_a, c1x_b, c1y_b, c2x_b, c2y_b;
    logic       busy_a, done_a, busy_b, done_b;
    int         vectors = 0, miscompares = 0, t_a, t_b;
    bit         done_seen;

    always #5 clk = ~clk;

    laser_search_ctrl u_a (
        .CLK(clk), .RST_N(rst_n), .START(start), .RD_ADDR(rd_addr_a),
        .RD_X(px[rd_addr_a]), .RD_Y(py[rd_addr_a]),
        .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a),
        .COVER(cover_a), .BUSY(busy_a), .DONE(done_a)
    );

    laser_search_ctrl #(.MAX_PASS(1)) u_b (
        .CLK(clk), .RST_N(rst_n), .START(start), .RD_ADDR(rd_addr_b),
        .RD_X(px[rd_addr_b]), .RD_Y(py[rd_addr_b]),
        .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b),
        .COVER(cover_b), .BUSY(busy_b), .DONE(done_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input bit same);
        for (int i = 0; i < 64; i++) begin
            px[i] = same ? 4'd5 : (i < 20 ? 4'd3 : 4'd12);
            py[i] = px[i];
        end
    endtask

    task automatic run(input bit dbl);
        t_a = 0;
        t_b = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 45000 && t_a == 0; n++) begin
            @(posedge clk);
            #1;
            if (dbl && n == 100) start = 1'b1;
            if (dbl && n == 101) start = 1'b0;
            if (n == 1) chk("busy_start", busy_a, 1);
            if (dbl && n == 1)  chk("rd_addr_1", rd_addr_a, 1);
            if (dbl && n == 39) chk("rd_addr_39", rd_addr_a, 39);
            if (dbl && n == 40) chk("rd_addr_eval", rd_addr_a, 0);
            if (dbl && n == 41) chk("rd_addr_next0", rd_addr_a, 0);
            if (dbl && n == 42) chk("rd_addr_next1", rd_addr_a, 1);
            if (done_b && t_b == 0) t_b = n;
            if (done_a && t_a == 0) t_a = n;
        end
        @(posedge clk);
        #1;
        chk("done_pulse", done_a, 0);
        chk("busy_end", busy_a, 0);
    endtask

    initial begin
        load(1'b0);
        repeat (3) @(negedge clk);
        chk("reset_outs", {c1x_a, c1y_a, c2x_a, c2y_a, cover_a, busy_a, done_a}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5000) @(negedge clk);
        chk("busy_mid", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_outs", {rd_addr_a, c1x_a, c1y_a, c2x_a, c2y_a, cover_a, done_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            done_seen |= done_a | busy_a;
        end
        chk("idle_after_rst", done_seen, 0);
        chk("idle_rd_addr", rd_addr_a, 0);

        run(1'b1);
        chk("clu_done_cyc", t_a, 41987);
        chk("clu_c1", {c1x_a, c1y_a}, {4'd1, 4'd0});
        chk("clu_c2", {c2x_a, c2y_a}, {4'd12, 4'd8});
        chk("clu_cover", cover_a, 40);
        chk("mp1_done_cyc", t_b, 20994);
        chk("mp1_c1", {c1x_b, c1y_b}, {4'd1, 4'd0});
        chk("mp1_c2", {c2x_b, c2y_b}, {4'd12, 4'd8});
        chk("mp1_cover", cover_b, 40);

        load(1'b1);
        run(1'b0);
        chk("same_done_cyc", t_a, 41987);
        chk("same_c1", {c1x_a, c1y_a}, {4'd5, 4'd1});
        chk("same_c2", {c2x_a, c2y_a}, {4'd0, 4'd0});
        chk("same_cover", cover_a, 40);
        chk("same_mp1_cyc", t_b, 20994);
        chk("same_mp1_c1", {c1x_b, c1y_b}, {4'd5, 4'd1});
        chk("same_mp1_c2", {c2x_b, c2y_b}, {4'd0, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
